// File: rtl/pc_sequencer_if.sv
// IMEM fetch port: request/acknowledge handshake with a byte address.
// The master side (pc_sequencer) drives req/addr and receives ack.
interface pc_sequencer_if #(
  parameter int AW = 12
);
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;

  modport master (
    output req,
    output addr,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// RV32 fetch-side PC sequencer: BOOT/FETCH/REDIRECT/HALTED control of IMEM.
// Optional macro PC_SEQ_MISALIGN_TRAP_EN traps misaligned redirect targets.
module pc_sequencer #(
  parameter int                     ADDR_W_IMEM = 12,
  parameter logic [ADDR_W_IMEM-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W_IMEM-1:0] TRAP_VEC    = 'h010
) (
  input  logic                   clock,
  input  logic                   async_reset,
  pc_sequencer_if.master         imem,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_W_IMEM-1:0] redirect_addr,
  input  logic                   trap,
  input  logic                   trap_return,
  input  logic                   halt_req,
  input  logic                   resume_req,
  output logic                   inst_valid,
  output logic [ADDR_W_IMEM-1:0] pc_out,
  output logic [ADDR_W_IMEM-1:0] epc,
  output logic                   halted,
  output logic                   misaligned
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_REDIR,
    S_HALT
  } state_e;

  localparam logic [ADDR_W_IMEM-1:0] ALIGN =
    ~ADDR_W_IMEM'(3);
  localparam logic [ADDR_W_IMEM-1:0] STEP =
    ADDR_W_IMEM'(4);

  state_e                 state_q;
  logic [ADDR_W_IMEM-1:0] pc_q;
  logic [ADDR_W_IMEM-1:0] epc_q;
  logic                   halted_q;
  logic                   mis_q;

  logic                   req;
  logic                   evt;
  logic                   accept;
  logic [ADDR_W_IMEM-1:0] redir_tgt;
  logic [ADDR_W_IMEM-1:0] ret_tgt;
  logic                   redir_bad;
  logic                   ret_bad;

  assign req    = (state_q == S_FETCH) & ~stall;
  assign evt    = trap | redirect_valid
                | trap_return | halt_req;
  assign accept = req & imem.ack & ~evt;

  assign redir_tgt = redirect_addr & ALIGN;
  assign ret_tgt   = epc_q & ALIGN;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign redir_bad = |redirect_addr[1:0];
  assign ret_bad   = |epc_q[1:0];
`else
  assign redir_bad = 1'b0;
  assign ret_bad   = 1'b0;
`endif

  assign imem.req   = req;
  assign imem.addr  = pc_q;
  assign inst_valid = accept;
  assign pc_out     = pc_q;
  assign epc        = epc_q;
  assign halted     = halted_q;
  assign misaligned = mis_q;

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      unique case (state_q)
        S_BOOT:  state_q <= S_FETCH;
        S_REDIR: state_q <= S_FETCH;
        S_HALT: begin
          if (resume_req) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
          end else if (redirect_valid) begin
            pc_q <= redir_tgt;
          end
        end
        S_FETCH: begin
          // Any event drops a coincident ack; pc only steps on accept.
          if (trap) begin
            epc_q   <= pc_q;
            pc_q    <= TRAP_VEC;
            state_q <= S_REDIR;
          end else if (redirect_valid) begin
            state_q <= S_REDIR;
            if (redir_bad) begin
              mis_q <= 1'b1;
              epc_q <= pc_q;
              pc_q  <= TRAP_VEC;
            end else begin
              pc_q <= redir_tgt;
            end
          end else if (trap_return) begin
            state_q <= S_REDIR;
            if (ret_bad) begin
              mis_q <= 1'b1;
              epc_q <= pc_q;
              pc_q  <= TRAP_VEC;
            end else begin
              pc_q <= ret_tgt;
            end
          end else if (halt_req) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (accept) begin
            pc_q <= pc_q + STEP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer.
// Expected outputs come from a transaction-level PC model.
module tb_pc_sequencer;

  localparam logic [11:0] TRAP = 12'h010;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit MT = 1'b1;
`else
  localparam bit MT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        async_reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_addr = '0;
  logic        trap = 1'b0;
  logic        trap_return = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic        inst_valid;
  logic [11:0] pc_out;
  logic [11:0] epc;
  logic        halted;
  logic        misaligned;

  pc_sequencer_if #(.AW(12)) imem ();

  pc_sequencer dut (
    .clock          (clock),
    .async_reset    (async_reset),
    .imem           (imem.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap           (trap),
    .trap_return    (trap_return),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .inst_valid     (inst_valid),
    .pc_out         (pc_out),
    .epc            (epc),
    .halted         (halted),
    .misaligned     (misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [11:0] addr;
    logic        valid;
    logic        halted;
    logic [11:0] epc;
    logic        mis;
  } exp_t;

  exp_t        sq[$];
  logic [11:0] aq[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  // Model: pc, saved pc, halt flag, bubble cycles before fetch resumes.
  logic [11:0] mpc;
  logic [11:0] mepc;
  bit          mhalt;
  bit          mmis;
  int          mgap;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mpc   = 12'h000;
    mepc  = 12'h000;
    mhalt = 1'b0;
    mmis  = 1'b0;
    mgap  = 1;
    aq.delete();
    sq.delete();
  endfunction

  // Jump to target t: aligned load, or trap when misaligned traps are on.
  function automatic bit jump(logic [11:0] t);
    if (MT && t[1:0] != 2'b00) begin
      mepc = mpc;
      mpc  = TRAP;
      return 1'b1;
    end
    mpc = t & 12'hFFC;
    return 1'b0;
  endfunction

  task automatic step(input bit st, input bit ak,
                      input bit rv, input logic [11:0] ra,
                      input bit tr, input bit trt,
                      input bit hr, input bit rs);
    exp_t e;
    bit   acc;
    bit   nmis;
    stall          = st;
    imem.ack       = ak;
    redirect_valid = rv;
    redirect_addr  = ra;
    trap           = tr;
    trap_return    = trt;
    halt_req       = hr;
    resume_req     = rs;
    e.req    = !mhalt && mgap == 0 && !st;
    e.addr   = mpc;
    e.halted = mhalt;
    e.epc    = mepc;
    e.mis    = mmis;
    acc      = e.req && ak && !(tr || rv || trt || hr);
    e.valid  = acc;
    sq.push_back(e);
    if (acc) aq.push_back(mpc);
    nmis = 1'b0;
    if (mgap > 0) begin
      mgap--;
    end else if (mhalt) begin
      if (rs) mhalt = 1'b0;
      else if (rv) mpc = ra & 12'hFFC;
    end else if (tr) begin
      mepc = mpc;
      mpc  = TRAP;
      mgap = 1;
    end else if (rv) begin
      nmis = jump(ra);
      mgap = 1;
    end else if (trt) begin
      nmis = jump(mepc);
      mgap = 1;
    end else if (hr) begin
      mhalt = 1'b1;
    end else if (acc) begin
      mpc = mpc + 12'd4;
    end
    mmis = nmis;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit ak);
    for (int i = 0; i < n; i++)
      step(0, ak, 0, 12'h0, 0, 0, 0, 0);
  endtask

  task automatic goto(input logic [11:0] a);
    step(0, 0, 1, a, 0, 0, 0, 0);
    idle(1, 0);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_req"},    imem.req,   0);
    chk({tag, "_addr"},   imem.addr,  12'h000);
    chk({tag, "_valid"},  inst_valid, 0);
    chk({tag, "_pc_out"}, pc_out,     12'h000);
    chk({tag, "_epc"},    epc,        12'h000);
    chk({tag, "_halted"}, halted,     0);
    chk({tag, "_mis"},    misaligned, 0);
  endtask

  always @(negedge clock) begin
    if (mon_en && sq.size() > 0) begin
      exp_t e;
      e = sq.pop_front();
      chk("imem_req", imem.req, e.req);
      if (e.req) chk("imem_addr", imem.addr, e.addr);
      chk("inst_valid", inst_valid, e.valid);
      chk("halted", halted, e.halted);
      chk("epc", epc, e.epc);
      chk("misaligned", misaligned, e.mis);
      if (inst_valid) begin
        if (aq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pc_out unexpected accept pc=%0h",
                   pc_out);
        end else begin
          chk("pc_out", pc_out, aq.pop_front());
        end
      end
    end
  end

  initial begin
    imem.ack = 1'b0;
    #12;
    reset_checks("reset");
    @(posedge clock);
    #1;
    async_reset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Boot with constant ack: 0,4,8,...
    idle(6, 1);
    // Wrap at top of address space
    goto(12'hFF8);
    idle(4, 1);
    // Redirect coinciding with ack
    goto(12'h020);
    step(0, 1, 1, 12'h100, 0, 0, 0, 0);
    idle(3, 1);
    // Trap then trap return
    goto(12'h040);
    step(0, 1, 0, 12'h0, 1, 0, 0, 0);
    idle(3, 1);
    step(0, 1, 0, 12'h0, 0, 1, 0, 0);
    idle(3, 1);
    // Halt during stall, debug PC write, resume
    goto(12'h080);
    step(1, 1, 0, 12'h0, 0, 0, 1, 0);
    step(1, 1, 1, 12'h200, 0, 0, 1, 0);
    step(0, 1, 0, 12'h0, 0, 0, 0, 0);
    step(0, 1, 1, 12'h300, 0, 0, 0, 1);
    idle(3, 1);
    // Misaligned redirect target
    goto(12'h102);
    idle(3, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 8,
           12'($urandom),
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 25);
    end

    // Reset in the middle of an active fetch
    goto(12'h040);
    step(0, 1, 0, 12'h0, 1, 0, 0, 0);
    idle(3, 1);
    mon_en = 1'b0;
    stall    = 1'b0;
    imem.ack = 1'b1;
    #2;
    async_reset = 1'b1;
    #1;
    reset_checks("midreset");
    @(posedge clock);
    #1;
    async_reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    idle(5, 1);

    chk("drain", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
